// File: rtl/conv_bn_issuer_if.sv
// Upstream (pixel, weight) pair stream and downstream result stream of conv_bn_issuer.
interface conv_bn_issuer_if #(
    parameter int WIDTH_A  = 18,
    parameter int WIDTH_B  = 18,
    parameter int WIDTH_eW = 18,
    parameter int WIDTH_eB = 18,
    parameter int WIDTH_R  = 18
);
    logic                in_valid;
    logic                in_ready;
    logic [WIDTH_A-1:0]  in_a;
    logic [WIDTH_B-1:0]  in_b;
    logic [WIDTH_eW-1:0] cfg_ew;
    logic [WIDTH_eB-1:0] cfg_eb;
    logic                res_valid;
    logic                res_ready;
    logic [WIDTH_R-1:0]  res_data;

    modport master (
        output in_valid, in_a, in_b, cfg_ew, cfg_eb, res_ready,
        input  in_ready, res_valid, res_data
    );

    modport slave (
        input  in_valid, in_a, in_b, cfg_ew, cfg_eb, res_ready,
        output in_ready, res_valid, res_data
    );
endinterface

// File: rtl/conv_bn_issuer.sv
// Conv_BN window initiator: ping-pong pair banks, burst issue FSM with credit limit,
// MA capture after conv_finish, shift/saturate into a 2-entry result FIFO.
module conv_bn_issuer #(
    parameter int NUM_conv_ele = 9,
    parameter int WIDTH_A      = 18,
    parameter int WIDTH_B      = 18,
    parameter int WIDTH_eW     = 18,
    parameter int WIDTH_eB     = 18,
    parameter int WIDTH_o      = 96,
    parameter int WIDTH_R      = 18,
    parameter int RES_SHIFT    = 0,
    parameter int RES_LAT      = 2
) (
    input  logic                clk,
    input  logic                reset,
    conv_bn_issuer_if.slave     bus,
    output logic                conv_start,
    output logic [WIDTH_A-1:0]  conv_a,
    output logic [WIDTH_B-1:0]  conv_b,
    output logic [WIDTH_eW-1:0] conv_ew,
    output logic [WIDTH_eB-1:0] conv_eb,
    input  logic                conv_finish,
    input  logic [WIDTH_o-1:0]  mac_p,
    output logic                busy
);
    localparam int IW = $clog2(NUM_conv_ele);
    localparam int GW = $clog2(NUM_conv_ele + 2);
    localparam logic signed [WIDTH_o-1:0] R_MAX =
        {{(WIDTH_o-WIDTH_R+1){1'b0}}, {(WIDTH_R-1){1'b1}}};
    localparam logic signed [WIDTH_o-1:0] R_MIN =
        {{(WIDTH_o-WIDTH_R+1){1'b1}}, {(WIDTH_R-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

    logic [WIDTH_A-1:0]  bank_a_mem [2][NUM_conv_ele];
    logic [WIDTH_B-1:0]  bank_b_mem [2][NUM_conv_ele];
    logic [WIDTH_eW-1:0] ew_mem [2];
    logic [WIDTH_eB-1:0] eb_mem [2];

    logic [1:0]          full_q, full_d;
    logic                wr_bank_q, wr_bank_d;
    logic [IW-1:0]       wr_idx_q, wr_idx_d;
    logic                rd_bank_q, rd_bank_d;
    logic [IW-1:0]       rd_idx_q, rd_idx_d;
    state_t              state_q, state_d;
    logic [GW-1:0]       gap_q, gap_d;
    logic [1:0]          credits_q, credits_d;
    logic [1:0]          inflight_q, inflight_d;
    logic                fin_q;
    logic [RES_LAT-1:0]  pipe_q, pipe_d;
    logic                start_q, start_d;
    logic [WIDTH_A-1:0]  a_q, a_d;
    logic [WIDTH_B-1:0]  b_q, b_d;
    logic [WIDTH_eW-1:0] ew_q, ew_d;
    logic [WIDTH_eB-1:0] eb_q, eb_d;
    logic [WIDTH_R-1:0]  fifo_q [2];
    logic [WIDTH_R-1:0]  fifo_d [2];
    logic                wp_q, wp_d, rp_q, rp_d;
    logic [1:0]          cnt_q, cnt_d;

    logic                accept, free, pop, fin_rise, capture;
    logic signed [WIDTH_o-1:0] shifted;
    logic [WIDTH_R-1:0]  sat;

    // Write bank is only ever full when both banks are full.
    assign bus.in_ready  = !full_q[wr_bank_q];
    assign accept        = bus.in_valid && bus.in_ready;
    assign pop           = bus.res_valid && bus.res_ready;
    assign fin_rise      = conv_finish && !fin_q && (inflight_q != 2'd0);
    assign capture       = pipe_q[RES_LAT-1];
    assign bus.res_valid = (cnt_q != 2'd0);
    assign bus.res_data  = fifo_q[rp_q];
    assign conv_start    = start_q;
    assign conv_a        = a_q;
    assign conv_b        = b_q;
    assign conv_ew       = ew_q;
    assign conv_eb       = eb_q;
    assign busy = (|full_q) || (state_q != IDLE) || (credits_q != 2'd0);

    always_ff @(posedge clk) begin
        if (accept) begin
            bank_a_mem[wr_bank_q][wr_idx_q] <= bus.in_a;
            bank_b_mem[wr_bank_q][wr_idx_q] <= bus.in_b;
            if (wr_idx_q == '0) begin
                ew_mem[wr_bank_q] <= bus.cfg_ew;
                eb_mem[wr_bank_q] <= bus.cfg_eb;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_bank_d = rd_bank_q;
        rd_idx_d  = rd_idx_q;
        gap_d     = (gap_q != '0) ? gap_q - 1'b1 : '0;
        start_d   = 1'b0;
        a_d       = '0;
        b_d       = '0;
        ew_d      = '0;
        eb_d      = '0;
        free      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (full_q[rd_bank_q] && gap_q == '0 && credits_q < 2'd2) begin
                    state_d  = BURST;
                    start_d  = 1'b1;
                    a_d      = bank_a_mem[rd_bank_q][0];
                    b_d      = bank_b_mem[rd_bank_q][0];
                    ew_d     = ew_mem[rd_bank_q];
                    eb_d     = eb_mem[rd_bank_q];
                    rd_idx_d = IW'(1);
                    gap_d    = GW'(NUM_conv_ele + 1);
                end
            end
            BURST: begin
                a_d = bank_a_mem[rd_bank_q][rd_idx_q];
                b_d = bank_b_mem[rd_bank_q][rd_idx_q];
                if (rd_idx_q == IW'(NUM_conv_ele - 1)) begin
                    free      = 1'b1;
                    rd_bank_d = ~rd_bank_q;
                    rd_idx_d  = '0;
                    state_d   = (gap_q != '0) ? GAP : IDLE;
                end else begin
                    rd_idx_d = rd_idx_q + 1'b1;
                end
            end
            GAP: begin
                if (gap_q <= GW'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        wr_idx_d  = wr_idx_q;
        if (accept) begin
            if (wr_idx_q == IW'(NUM_conv_ele - 1)) begin
                full_d[wr_bank_q] = 1'b1;
                wr_idx_d          = '0;
                wr_bank_d         = ~wr_bank_q;
            end else begin
                wr_idx_d = wr_idx_q + 1'b1;
            end
        end
        if (free) full_d[rd_bank_q] = 1'b0;
    end

    always_comb begin
        credits_d = credits_q;
        unique case ({start_d, pop})
            2'b10:   credits_d = credits_q + 2'd1;
            2'b01:   credits_d = credits_q - 2'd1;
            default: credits_d = credits_q;
        endcase
        inflight_d = inflight_q;
        unique case ({start_d, fin_rise})
            2'b10:   inflight_d = inflight_q + 2'd1;
            2'b01:   inflight_d = inflight_q - 2'd1;
            default: inflight_d = inflight_q;
        endcase
        pipe_d = (pipe_q << 1) | RES_LAT'(fin_rise);
    end

    always_comb begin
        shifted = $signed(mac_p) >>> RES_SHIFT;
        if (shifted > R_MAX)      sat = {1'b0, {(WIDTH_R-1){1'b1}}};
        else if (shifted < R_MIN) sat = {1'b1, {(WIDTH_R-1){1'b0}}};
        else                      sat = shifted[WIDTH_R-1:0];
    end

    // Credits bound the FIFO occupancy, so a push never finds it full.
    always_comb begin
        fifo_d = fifo_q;
        wp_d   = wp_q;
        rp_d   = rp_q;
        cnt_d  = cnt_q;
        if (capture) begin
            fifo_d[wp_q] = sat;
            wp_d         = ~wp_q;
        end
        if (pop) rp_d = ~rp_q;
        unique case ({capture, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q     <= '0;
            wr_bank_q  <= 1'b0;
            wr_idx_q   <= '0;
            rd_bank_q  <= 1'b0;
            rd_idx_q   <= '0;
            state_q    <= IDLE;
            gap_q      <= '0;
            credits_q  <= '0;
            inflight_q <= '0;
            fin_q      <= 1'b0;
            pipe_q     <= '0;
            start_q    <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            ew_q       <= '0;
            eb_q       <= '0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            wp_q       <= 1'b0;
            rp_q       <= 1'b0;
            cnt_q      <= '0;
        end else begin
            full_q     <= full_d;
            wr_bank_q  <= wr_bank_d;
            wr_idx_q   <= wr_idx_d;
            rd_bank_q  <= rd_bank_d;
            rd_idx_q   <= rd_idx_d;
            state_q    <= state_d;
            gap_q      <= gap_d;
            credits_q  <= credits_d;
            inflight_q <= inflight_d;
            fin_q      <= conv_finish;
            pipe_q     <= pipe_d;
            start_q    <= start_d;
            a_q        <= a_d;
            b_q        <= b_d;
            ew_q       <= ew_d;
            eb_q       <= eb_d;
            fifo_q     <= fifo_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            cnt_q      <= cnt_d;
        end
    end
endmodule

// File: tb/tb_conv_bn_issuer.sv
// Self-checking bench for conv_bn_issuer: window bursts, start spacing,
// result saturation, credit back-pressure, mid-burst reset, spurious finish.
module tb_conv_bn_issuer;
    localparam int N     = 9;
    localparam int SHIFT = 2;
    localparam longint RMAX = 131071;
    localparam longint RMIN = -131072;

    typedef struct {
        logic [17:0] a, b, ew, eb;
    } pair_t;

    logic        clk;
    logic        reset;
    logic        conv_start;
    logic [17:0] conv_a, conv_b, conv_ew, conv_eb;
    logic        conv_finish;
    logic [95:0] mac_p;
    logic        busy;

    conv_bn_issuer_if bus ();

    conv_bn_issuer #(.RES_SHIFT(SHIFT)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .conv_start  (conv_start),
        .conv_a      (conv_a),
        .conv_b      (conv_b),
        .conv_ew     (conv_ew),
        .conv_eb     (conv_eb),
        .conv_finish (conv_finish),
        .mac_p       (mac_p),
        .busy        (busy)
    );

    int     n_assert, n_fail, cyc, stall_cnt, spur_cnt, spur_done;
    bit     rv_seen;
    pair_t  src_q[$];
    longint mac_q[$], fin_due[$];
    longint exp_a[$], exp_b[$], exp_ew[$], exp_eb[$], exp_r[$];
    longint got_a[$], got_b[$], got_ew[$], got_eb[$], got_r[$];
    longint tail_a[$], st_cyc[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint ref_res(input longint v);
        longint r;
        r = v >>> SHIFT;
        if (r > RMAX) r = RMAX;
        if (r < RMIN) r = RMIN;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Upstream source: presents queued pairs, retires them on handshake.
    initial begin
        bit fire;
        bus.in_valid = 1'b0;
        bus.in_a = '0; bus.in_b = '0; bus.cfg_ew = '0; bus.cfg_eb = '0;
        forever begin
            @(negedge clk);
            fire = bus.in_valid && bus.in_ready && !reset;
            if (bus.in_valid && !bus.in_ready) stall_cnt++;
            @(posedge clk);
            #1;
            if (fire) void'(src_q.pop_front());
            if (src_q.size() > 0) begin
                bus.in_valid = 1'b1;
                bus.in_a = src_q[0].a; bus.in_b = src_q[0].b;
                bus.cfg_ew = src_q[0].ew; bus.cfg_eb = src_q[0].eb;
            end else begin
                bus.in_valid = 1'b0;
            end
        end
    end

    // Conv_BN + MA model: finish N cycles after start, mac_p held from finish.
    initial begin
        longint mv;
        conv_finish = 1'b0;
        mac_p = '0;
        spur_done = 0;
        forever begin
            @(negedge clk);
            conv_finish = 1'b0;
            if (reset) begin
                fin_due.delete();
            end else begin
                if (conv_start) fin_due.push_back(cyc + N);
                if (fin_due.size() > 0 && fin_due[0] == cyc) begin
                    void'(fin_due.pop_front());
                    conv_finish = 1'b1;
                    mv = (mac_q.size() > 0) ? mac_q.pop_front() : 0;
                    mac_p = {{32{mv[63]}}, mv};
                end else if (spur_cnt != spur_done) begin
                    spur_done++;
                    conv_finish = 1'b1;
                end
            end
        end
    end

    // Observer: records bursts, the cycle after each burst, and popped results.
    initial begin
        int cap;
        bit tail;
        cap = 0;
        tail = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                cap = 0;
                tail = 1'b0;
            end else begin
                if (bus.res_valid) rv_seen = 1'b1;
                if (bus.res_valid && bus.res_ready) got_r.push_back($signed(bus.res_data));
                if (conv_start) begin
                    st_cyc.push_back(cyc);
                    got_ew.push_back(conv_ew);
                    got_eb.push_back(conv_eb);
                    cap = N;
                end
                if (cap > 0) begin
                    got_a.push_back(conv_a);
                    got_b.push_back(conv_b);
                    cap--;
                    tail = (cap == 0);
                end else if (tail) begin
                    tail_a.push_back(conv_a);
                    tail = 1'b0;
                end
            end
        end
    end

    task automatic push_win(input bit rnd, input longint mv);
        pair_t p;
        logic [17:0] ew, eb;
        ew = rnd ? 18'($urandom_range(0, 262143)) : 18'd2;
        eb = rnd ? 18'($urandom_range(0, 262143)) : 18'd5;
        exp_ew.push_back(ew);
        exp_eb.push_back(eb);
        for (int i = 0; i < N; i++) begin
            p.a  = rnd ? 18'($urandom_range(0, 262143)) : 18'(i + 1);
            p.b  = rnd ? 18'($urandom_range(0, 262143)) : 18'd1;
            p.ew = (i == 0) ? ew : ~ew;
            p.eb = (i == 0) ? eb : ~eb;
            exp_a.push_back(p.a);
            exp_b.push_back(p.b);
            src_q.push_back(p);
        end
        mac_q.push_back(mv);
        exp_r.push_back(ref_res(mv));
    endtask

    task automatic clear_all();
        exp_a.delete(); exp_b.delete(); exp_ew.delete(); exp_eb.delete();
        exp_r.delete(); got_a.delete(); got_b.delete(); got_ew.delete();
        got_eb.delete(); got_r.delete(); tail_a.delete(); st_cyc.delete();
        mac_q.delete();
    endtask

    task automatic wait_done(input int ns, input int nr, input int bound);
        int t;
        t = 0;
        while ((st_cyc.size() < ns || got_r.size() < nr || tail_a.size() < ns) && t < bound) begin
            tick();
            t++;
        end
        repeat (5) tick();
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_starts"}, st_cyc.size(), exp_ew.size());
        chk({tag, "_npairs"}, got_a.size(), exp_a.size());
        chk({tag, "_nres"}, got_r.size(), exp_r.size());
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
            chk($sformatf("%s_a%0d", tag, i), got_a[i], exp_a[i]);
            chk($sformatf("%s_b%0d", tag, i), got_b[i], exp_b[i]);
        end
        for (int i = 0; i < exp_ew.size() && i < got_ew.size(); i++) begin
            chk($sformatf("%s_ew%0d", tag, i), got_ew[i], exp_ew[i]);
            chk($sformatf("%s_eb%0d", tag, i), got_eb[i], exp_eb[i]);
        end
        for (int i = 0; i < tail_a.size(); i++)
            chk($sformatf("%s_tail%0d", tag, i), tail_a[i], 0);
        for (int i = 0; i < exp_r.size() && i < got_r.size(); i++)
            chk($sformatf("%s_res%0d", tag, i), got_r[i], exp_r[i]);
    endtask

    initial begin
        n_assert = 0; n_fail = 0; cyc = 0; stall_cnt = 0; spur_cnt = 0;
        rv_seen = 1'b0;
        reset = 1'b1;
        bus.res_ready = 1'b1;
        repeat (3) tick();
        chk("rst_start", conv_start, 0);
        chk("rst_a", conv_a, 0);
        chk("rst_ew", conv_ew, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_data", bus.res_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        reset = 1'b0;
        tick();

        // Directed window a=1..9, b=1, ew=2, eb=5
        push_win(1'b0, 100);
        wait_done(1, 1, 200);
        check_all("t1");
        chk("t1_idle_busy", busy, 0);

        // Back-to-back random windows
        clear_all();
        stall_cnt = 0;
        for (int w = 0; w < 3; w++) push_win(1'b1, 100);
        wait_done(3, 3, 400);
        check_all("t2");
        chk("t2_stalls", stall_cnt, 0);
        if (st_cyc.size() == 3) begin
            chk("t2_gap1", st_cyc[1] - st_cyc[0], N + 2);
            chk("t2_gap2", st_cyc[2] - st_cyc[1], N + 2);
        end

        // Shift and saturation boundaries
        clear_all();
        push_win(1'b1, 64'sd1 <<< 40);
        push_win(1'b1, -(64'sd1 <<< 40));
        push_win(1'b1, 524287);
        push_win(1'b1, 524288);
        push_win(1'b1, -524288);
        push_win(1'b1, -524289);
        push_win(1'b1, -7);
        wait_done(7, 7, 800);
        check_all("t3");

        // Credit back-pressure with results held
        clear_all();
        bus.res_ready = 1'b0;
        for (int w = 0; w < 4; w++) push_win(1'b1, 100);
        repeat (90) tick();
        chk("t4_held_starts", st_cyc.size(), 2);
        chk("t4_res_valid", bus.res_valid, 1);
        chk("t4_in_ready", bus.in_ready, 0);
        chk("t4_busy", busy, 1);
        bus.res_ready = 1'b1;
        wait_done(4, 4, 400);
        check_all("t4");

        // Reset in the middle of a burst
        clear_all();
        push_win(1'b1, 100);
        for (int t = 0; t < 200 && got_a.size() < 4; t++) tick();
        chk("t5_mid_pairs", got_a.size(), 4);
        reset = 1'b1;
        #1;
        chk("t5_rst_start", conv_start, 0);
        chk("t5_rst_a", conv_a, 0);
        chk("t5_rst_b", conv_b, 0);
        chk("t5_rst_in_ready", bus.in_ready, 1);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_res_valid", bus.res_valid, 0);
        tick();
        reset = 1'b0;
        clear_all();
        tick();
        push_win(1'b1, -7);
        wait_done(1, 1, 200);
        repeat (30) tick();
        check_all("t5");

        // Spurious finish while idle
        clear_all();
        rv_seen = 1'b0;
        spur_cnt++;
        repeat (20) tick();
        chk("t6_spur_done", spur_done, spur_cnt);
        chk("t6_no_valid", rv_seen, 0);
        chk("t6_busy", busy, 0);
        push_win(1'b1, 524287);
        wait_done(1, 1, 200);
        check_all("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
